// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data-memory access controller: command opcodes and
// sequencer states.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_DUMP  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RSP
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer for the data memory port. Turns single and burst
// commands into write cycles or read/response pairs with backpressure.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic [W-1:0]  cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_data,
    output logic [AW-1:0] rsp_addr,
    output logic          rsp_last,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [W-1:0]  mem_wdata,
    output logic          mem_wen,
    input  logic [W-1:0]  mem_rdata
);

    localparam int DEPTH = 2 ** AW;

    state_t        state_q, state_d;
    logic [AW-1:0] curAddr_q, curAddr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;
    logic          rspValid_q, rspValid_d;
    logic [W-1:0]  rspData_q, rspData_d;
    logic [AW-1:0] rspAddr_q, rspAddr_d;
    logic          rspLast_q, rspLast_d;
    logic [AW-1:0] addrNext;

    assign addrNext = (curAddr_q == AW'(DEPTH - 1)) ? '0 : curAddr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            curAddr_q  <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            rspAddr_q  <= '0;
            rspLast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            curAddr_q  <= curAddr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rspValid_q <= rspValid_d;
            rspData_q  <= rspData_d;
            rspAddr_q  <= rspAddr_d;
            rspLast_q  <= rspLast_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        curAddr_d  = curAddr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        rspValid_d = rspValid_q;
        rspData_d  = rspData_q;
        rspAddr_d  = rspAddr_q;
        rspLast_d  = rspLast_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    curAddr_d = cmd_addr;
                    data_d    = cmd_data;
                    case (op_t'(cmd_op))
                        OP_READ:  begin cnt_d = '0;      state_d = RD; end
                        OP_WRITE: begin cnt_d = '0;      state_d = WR; end
                        OP_FILL:  begin cnt_d = cmd_len; state_d = WR; end
                        default:  begin cnt_d = cmd_len; state_d = RD; end
                    endcase
                end
            end
            WR: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    curAddr_d = addrNext;
                    cnt_d     = cnt_q - 1'b1;
                end
            end
            RD: begin
                rspData_d  = mem_rdata;
                rspAddr_d  = curAddr_q;
                rspLast_d  = (cnt_q == '0);
                rspValid_d = 1'b1;
                state_d    = RSP;
            end
            RSP: begin
                // Response fields stay frozen until the consumer takes the word.
                if (rsp_ready) begin
                    rspValid_d = 1'b0;
                    if (rspLast_q) begin
                        state_d = IDLE;
                    end else begin
                        curAddr_d = addrNext;
                        cnt_d     = cnt_q - 1'b1;
                        state_d   = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and write strobe are gated by reset so a reset cycle never writes.
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign mem_wen   = (state_q == WR) && !rst;
    assign busy      = (state_q != IDLE);
    assign mem_addr  = curAddr_q;
    assign mem_wdata = data_q;
    assign rsp_valid = rspValid_q;
    assign rsp_data  = rspData_q;
    assign rsp_addr  = rspAddr_q;
    assign rsp_last  = rspLast_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl attached to an 8-word memory whose
// power-up contents are mem[i]=i.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_addr = 3'd0;
    logic [2:0] cmd_len = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic [2:0] rsp_addr;
    logic       rsp_last;
    logic       busy;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wen;
    logic [7:0] mem_rdata;

    logic [7:0] memArray [8];
    logic [7:0] refMem [8];
    bit         randomRsp = 1'b0;
    int         compared = 0;
    int         mismatched = 0;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
    } wrExp_t;

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        logic       last;
    } rspExp_t;

    wrExp_t  wrQ [$];
    rspExp_t rspQ [$];

    mem_access_ctrl #(.W(8), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_last(rsp_last), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory under the controller: combinational read, write on rising edge.
    initial for (int i = 0; i < 8; i++) memArray[i] = 8'(i);
    always @(posedge clk) if (mem_wen) memArray[mem_addr] <= mem_wdata;
    assign mem_rdata = memArray[mem_addr];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walks the command's address range modulo 8 and queues
    // every write and response it implies; maxWrites truncates an aborted burst.
    task automatic modelCommand(input op_t op, input int addr, input int len, input logic [7:0] data, input int maxWrites);
        int n;
        n = (op == OP_READ || op == OP_WRITE) ? 1 : len + 1;
        for (int i = 0; i < n; i++) begin
            int a;
            a = (addr + i) % 8;
            if (op == OP_WRITE || op == OP_FILL) begin
                if (i < maxWrites) begin
                    wrQ.push_back('{a: 3'(a), d: data});
                    refMem[a] = data;
                end
            end else begin
                rspQ.push_back('{d: refMem[a], a: 3'(a), last: (i == n - 1)});
            end
        end
    endtask

    task automatic applyStimulus(input op_t op, input int addr, input int len, input logic [7:0] data,
                                 input int maxWrites, input bit checkBlocked);
        int waitCnt;
        waitCnt = 0;
        @(posedge clk); #1;
        cmd_op    = op;
        cmd_addr  = 3'(addr);
        cmd_len   = 3'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            if (checkBlocked) begin
                checkOutput("blockedNoReady", {31'd0, cmd_ready}, {31'd0, !busy});
                checkOutput("blockedNoWrite", {31'd0, mem_wen}, 32'd0);
            end
            waitCnt++;
            if (waitCnt > 200) begin
                checkOutput("acceptTimeout", 32'd1, 32'd0);
                cmd_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        modelCommand(op, addr, len, data, maxWrites);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && wrQ.size() == 0 && rspQ.size() == 0) return;
        end
        checkOutput("idleTimeout", 32'd1, 32'd0);
    endtask

    // Monitor: a handshake or write seen at the falling edge lands on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("noWriteInReset", {31'd0, mem_wen}, 32'd0);
        end else begin
            if (mem_wen) begin
                if (wrQ.size() == 0) begin
                    checkOutput("unexpectedWrite", {29'd0, mem_addr}, 32'hFFFF);
                end else begin
                    wrExp_t w;
                    w = wrQ.pop_front();
                    checkOutput("wrAddr", {29'd0, mem_addr}, {29'd0, w.a});
                    checkOutput("wrData", {24'd0, mem_wdata}, {24'd0, w.d});
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rspQ.size() == 0) begin
                    checkOutput("unexpectedRsp", {24'd0, rsp_data}, 32'hFFFF);
                end else begin
                    rspExp_t r;
                    r = rspQ.pop_front();
                    checkOutput("rspData", {24'd0, rsp_data}, {24'd0, r.d});
                    checkOutput("rspAddr", {29'd0, rsp_addr}, {29'd0, r.a});
                    checkOutput("rspLast", {31'd0, rsp_last}, {31'd0, r.last});
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (randomRsp) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        for (int i = 0; i < 8; i++) refMem[i] = 8'(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstRspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstCmdReady", {31'd0, cmd_ready}, 32'd0);
        checkOutput("rstMemAddr", {29'd0, mem_addr}, 32'd0);
        checkOutput("rstMemWdata", {24'd0, mem_wdata}, 32'd0);
        checkOutput("rstRspData", {24'd0, rsp_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idleCmdReady", {31'd0, cmd_ready}, 32'd1);

        $display("[TB] single write and read latency");
        applyStimulus(OP_WRITE, 5, 0, 8'hA5, 8, 1'b0);
        @(negedge clk);
        checkOutput("wrCycleWen", {31'd0, mem_wen}, 32'd1);
        checkOutput("wrCycleAddr", {29'd0, mem_addr}, 32'd5);
        checkOutput("wrCycleData", {24'd0, mem_wdata}, 32'hA5);
        checkOutput("wrCycleReady", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        checkOutput("wrDoneWen", {31'd0, mem_wen}, 32'd0);
        checkOutput("wrDoneReady", {31'd0, cmd_ready}, 32'd1);

        applyStimulus(OP_READ, 5, 0, 8'h00, 8, 1'b0);
        @(negedge clk);
        checkOutput("rdLatency1", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        checkOutput("rdLatency2", {31'd0, rsp_valid}, 32'd1);
        waitIdle();
        applyStimulus(OP_READ, 3, 0, 8'h00, 8, 1'b0);
        waitIdle();

        $display("[TB] wrapping fill and dump");
        applyStimulus(OP_FILL, 6, 3, 8'h3C, 8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("fillWen", {31'd0, mem_wen}, 32'd1);
        end
        @(negedge clk);
        checkOutput("fillEndWen", {31'd0, mem_wen}, 32'd0);
        waitIdle();
        applyStimulus(OP_DUMP, 6, 3, 8'h00, 8, 1'b0);
        waitIdle();

        $display("[TB] dump with backpressure");
        applyStimulus(OP_DUMP, 0, 7, 8'h00, 8, 1'b0);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(posedge clk); #1;
                if (rsp_valid && rsp_addr == 3'd2) found = 1'b1;
            end
            checkOutput("stallWordSeen", {31'd0, found}, 32'd1);
            rsp_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                checkOutput("stallValid", {31'd0, rsp_valid}, 32'd1);
                checkOutput("stallData", {24'd0, rsp_data}, {24'd0, refMem[2]});
                checkOutput("stallAddr", {29'd0, rsp_addr}, 32'd2);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
        end
        waitIdle();

        $display("[TB] reset during fill");
        applyStimulus(OP_FILL, 0, 7, 8'hFF, 2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abortWen", {31'd0, mem_wen}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abortIdleWen", {31'd0, mem_wen}, 32'd0);
        checkOutput("abortIdleBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortRspValid", {31'd0, rsp_valid}, 32'd0);
        applyStimulus(OP_DUMP, 0, 7, 8'h00, 8, 1'b0);
        waitIdle();

        $display("[TB] command held while busy");
        applyStimulus(OP_DUMP, 0, 3, 8'h00, 8, 1'b0);
        applyStimulus(OP_WRITE, 4, 0, 8'h5A, 8, 1'b1);
        waitIdle();
        checkOutput("heldWriteMem", {24'd0, memArray[4]}, 32'h5A);

        $display("[TB] randomized commands");
        randomRsp = 1'b1;
        for (int n = 0; n < 40; n++) begin
            applyStimulus(op_t'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
                          8'($urandom), 8, 1'b0);
        end
        waitIdle();
        randomRsp = 1'b0;
        rsp_ready = 1'b1;
        checkOutput("wrQueueEmpty", wrQ.size(), 32'd0);
        checkOutput("rspQueueEmpty", rspQ.size(), 32'd0);
        for (int i = 0; i < 8; i++) checkOutput("finalMem", {24'd0, memArray[i]}, {24'd0, refMem[i]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
